axi_wr_arb: RTL and testbench
=============================

Name: axi_wr_arb

Overview:
- Shares the single 64-bit AXI3 HP0 write channel between NREQ write-DMA requesters, e.g. AFE capture writer and frame-buffer fill.
- Round-robin arbitration with burst granularity: each AW grant is held until that burst's WLAST handshake.
- Downstream AWID carries the requester index; B responses are steered back by BID.
- Sits in system between the DMA engines and m_axi_aw*/w*/b*; read channels are untouched.

Parameters:
- NREQ, 2, number of requesters (2..4).
- AXI_AW, 32, address width.
- AXI_DW, 64, data width.
- AXI_IDW, 2, downstream ID width; must be >= clog2(NREQ).
- MAX_OUTS, 4, maximum outstanding bursts (AW accepted, B not yet returned) across all requesters.

Ports:
- clk  in  1  system clock (FCLK_CLK0 domain).
- rst  in  1  synchronous active-high reset.
- s_awaddr  in  NREQ*AXI_AW  per-requester AW address, packed with requester 0 in the LSBs.
- s_awlen  in  NREQ*8  per-requester burst length.
- s_awsize  in  NREQ*3  per-requester beat size.
- s_awburst  in  NREQ*2  per-requester burst type.
- s_awvalid  in  NREQ  per-requester AW valid.
- s_awready  out  NREQ  per-requester AW ready.
- s_wdata  in  NREQ*AXI_DW  per-requester write data.
- s_wstrb  in  NREQ*AXI_DW/8  per-requester write strobes.
- s_wlast  in  NREQ  per-requester last beat.
- s_wvalid  in  NREQ  per-requester W valid.
- s_wready  out  NREQ  per-requester W ready.
- s_bresp  out  NREQ*2  per-requester write response.
- s_bvalid  out  NREQ  per-requester B valid.
- s_bready  in  NREQ  per-requester B ready.
- m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid  out  AXI_IDW/AXI_AW/8/3/2/1  downstream AW.
- m_axi_awready  in  1  downstream AW ready.
- m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid  out  AXI_DW/AXI_DW/8/1/1  downstream W.
- m_axi_wready  in  1  downstream W ready.
- m_axi_bid  in  AXI_IDW  downstream response ID.
- m_axi_bresp  in  2  downstream response.
- m_axi_bvalid  in  1  downstream response valid.
- m_axi_bready  out  1  downstream response ready.
- busy  out  1  high whenever state != IDLE or outstanding count != 0.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0, outs_cnt=0.
  - All valid and ready outputs are 0; busy=0.
- State machine, IDLE -> AW -> W -> IDLE:
  - IDLE: when any s_awvalid is set and outs_cnt < MAX_OUTS, latch grant as the first requester at or after rr_ptr with awvalid set, then go to AW. No AW is accepted in the IDLE cycle itself.
  - AW: drive m_axi_aw* combinationally from the granted requester, with m_axi_awid = grant (zero-extended). Set s_awready[grant] = m_axi_awready. On handshake: go to W, outs_cnt+1, rr_ptr = grant+1 mod NREQ.
  - W: route the granted requester's W to m_axi_w*; s_wready[grant] = m_axi_wready. All other s_wready are 0. On a handshake with wlast=1, return to IDLE.
- Arbitration latency: minimum 2 cycles from s_awvalid to m_axi_awvalid (IDLE latch cycle, then AW).
- Throughput: back-to-back bursts cost one IDLE cycle each.
- W ordering: W beats are never interleaved between requesters, and W order equals AW order as AXI3 requires. W beats offered before the AW grant stall with wready=0.
- B channel:
  - Steering is combinational by BID: s_bvalid[m_axi_bid] = m_axi_bvalid and m_axi_bready = s_bready[m_axi_bid]; s_bresp is broadcast.
  - A BID >= NREQ is sunk with bready=1 and counted as a completion.
- Outstanding counter:
  - Width clog2(MAX_OUTS+1). +1 on AW handshake, -1 on B handshake; both in the same cycle gives no change.
  - At outs_cnt == MAX_OUTS, IDLE does not grant. Underflow cannot occur; a B with outs_cnt == 0 is ignored and the counter stays 0.
- Fairness: a requester that holds awvalid high is granted within NREQ grants.
- Requester protocol: a requester dropping awvalid before its handshake is a protocol violation. The arbiter keeps the grant; no recovery is needed.
- Reset mid-burst: all state clears the next cycle. Downstream recovery is the PS reset's job; the arbiter makes no attempt to complete the burst.

Decomposition:
- Shared package axi_arb_pkg: state encoding (IDLE=0, AW=1, W=2) and the helper function clog2.
- Natural sub-module: rr_arbiter, which takes a NREQ request vector and rr_ptr and returns a one-hot/index grant. It is combinational and reused by a future read arbiter.

Test Plan:
- Single requester: req0 issues AW addr 0x1000_0000, len 3 -> m_axi_awid=0 and address matches; 4 W beats pass with wlast on beat 4; B OKAY reaches s_bvalid[0] only; busy returns to 0.
- Contention: req0 and req1 both hold awvalid from reset release, with rr_ptr=0 -> grant order 0,1,0,1 over 4 bursts; downstream W beats are never interleaved.
- Backpressure: m_axi_wready toggles 1,0,0,1 -> data order is preserved; s_wready[grant] mirrors m_axi_wready exactly.
- Outstanding cap: MAX_OUTS=4 with B withheld -> the 5th AW is not granted; one B returned -> the grant resumes exactly 1 cycle later in IDLE.
- Simultaneous events: an AW handshake and a B handshake in the same cycle -> outs_cnt is unchanged; a B with bid=1 while req0 is in W -> routed to s_bvalid[1] without stalling W.
- Reset mid-W: assert rst on beat 2 of len=7 -> the next cycle shows all valid/ready = 0, outs_cnt=0, state IDLE.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI write-channel arbiter and its round-robin core.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester at or after ptr_i, wrapping.
module rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_vld_o
);

    // Wrapped requests (below ptr) are scanned first so the at-or-after pass overrides them.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_i[j] && (IW'(j) < ptr_i)) begin
                gnt_idx_o = IW'(j);
                gnt_vld_o = 1'b1;
            end
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req_i[j] && (IW'(j) >= ptr_i)) begin
                gnt_idx_o = IW'(j);
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arb.sv
// Burst-granular round-robin arbiter sharing one AXI3 write port among NREQ DMA writers.
module axi_wr_arb
    import axi_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AXI_AW   = 32,
    parameter int AXI_DW   = 64,
    parameter int AXI_IDW  = 2,
    parameter int MAX_OUTS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ*AXI_AW-1:0]   s_awaddr,
    input  logic [NREQ*8-1:0]        s_awlen,
    input  logic [NREQ*3-1:0]        s_awsize,
    input  logic [NREQ*2-1:0]        s_awburst,
    input  logic [NREQ-1:0]          s_awvalid,
    output logic [NREQ-1:0]          s_awready,
    input  logic [NREQ*AXI_DW-1:0]   s_wdata,
    input  logic [NREQ*AXI_DW/8-1:0] s_wstrb,
    input  logic [NREQ-1:0]          s_wlast,
    input  logic [NREQ-1:0]          s_wvalid,
    output logic [NREQ-1:0]          s_wready,
    output logic [NREQ*2-1:0]        s_bresp,
    output logic [NREQ-1:0]          s_bvalid,
    input  logic [NREQ-1:0]          s_bready,
    output logic [AXI_IDW-1:0]       m_axi_awid,
    output logic [AXI_AW-1:0]        m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [AXI_DW-1:0]        m_axi_wdata,
    output logic [AXI_DW/8-1:0]      m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [AXI_IDW-1:0]       m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic                     busy
);

    localparam int IW = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int OW = clog2(MAX_OUTS + 1);
    localparam int SW = AXI_DW / 8;

    state_e        state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [OW-1:0] outs_q, outs_d;
    logic [IW-1:0] arb_idx;
    logic          arb_vld;
    logic          aw_hs, w_last_hs, b_hs, b_dec;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req_i     (s_awvalid),
        .ptr_i     (rr_ptr_q),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    assign m_axi_awid    = AXI_IDW'(grant_q);
    assign m_axi_awaddr  = s_awaddr[int'(grant_q)*AXI_AW +: AXI_AW];
    assign m_axi_awlen   = s_awlen[int'(grant_q)*8 +: 8];
    assign m_axi_awsize  = s_awsize[int'(grant_q)*3 +: 3];
    assign m_axi_awburst = s_awburst[int'(grant_q)*2 +: 2];
    assign m_axi_awvalid = (state_q == ST_AW) && s_awvalid[grant_q];

    assign m_axi_wdata   = s_wdata[int'(grant_q)*AXI_DW +: AXI_DW];
    assign m_axi_wstrb   = s_wstrb[int'(grant_q)*SW +: SW];
    assign m_axi_wlast   = s_wlast[grant_q];
    assign m_axi_wvalid  = (state_q == ST_W) && s_wvalid[grant_q];

    assign s_bresp       = {NREQ{m_axi_bresp}};

    assign aw_hs     = m_axi_awvalid && m_axi_awready;
    assign w_last_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
    assign b_hs      = m_axi_bvalid && m_axi_bready;
    assign b_dec     = b_hs && (outs_q != '0);

    // Out-of-range BIDs fall through with bready=1 so stray responses drain.
    always_comb begin
        s_awready    = '0;
        s_wready     = '0;
        s_bvalid     = '0;
        m_axi_bready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IW'(i)) begin
                s_awready[i] = (state_q == ST_AW) && m_axi_awready;
                s_wready[i]  = (state_q == ST_W) && m_axi_wready;
            end
            if (m_axi_bid == AXI_IDW'(i)) begin
                s_bvalid[i]  = m_axi_bvalid;
                m_axi_bready = s_bready[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld && (outs_q < OW'(MAX_OUTS))) begin
                    grant_d = arb_idx;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (aw_hs) begin
                    state_d  = ST_W;
                    rr_ptr_d = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            ST_W: begin
                if (w_last_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        outs_d = outs_q;
        if (aw_hs && !b_dec)      outs_d = outs_q + 1'b1;
        else if (!aw_hs && b_dec) outs_d = outs_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            outs_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            outs_q   <= outs_d;
        end
    end

    assign busy = (state_q != ST_IDLE) || (outs_q != '0);

endmodule

// File: tb/tb_axi_wr_arb.sv
// Directed bench for axi_wr_arb: arbitration order, W routing, B steering, outstanding cap, reset.
module tb_axi_wr_arb;
    import axi_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int IDW  = 2;
    localparam int MO   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ*AW-1:0]     s_awaddr;
    logic [NREQ*8-1:0]      s_awlen;
    logic [NREQ*3-1:0]      s_awsize;
    logic [NREQ*2-1:0]      s_awburst;
    logic [NREQ-1:0]        s_awvalid, s_awready;
    logic [NREQ*DW-1:0]     s_wdata;
    logic [NREQ*DW/8-1:0]   s_wstrb;
    logic [NREQ-1:0]        s_wlast, s_wvalid, s_wready;
    logic [NREQ*2-1:0]      s_bresp;
    logic [NREQ-1:0]        s_bvalid, s_bready;
    logic [IDW-1:0]         m_axi_awid;
    logic [AW-1:0]          m_axi_awaddr;
    logic [7:0]             m_axi_awlen;
    logic [2:0]             m_axi_awsize;
    logic [1:0]             m_axi_awburst;
    logic                   m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]          m_axi_wdata;
    logic [DW/8-1:0]        m_axi_wstrb;
    logic                   m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [IDW-1:0]         m_axi_bid;
    logic [1:0]             m_axi_bresp;
    logic                   m_axi_bvalid, m_axi_bready;
    logic                   busy;

    int n_chk  = 0;
    int n_pass = 0;

    axi_wr_arb #(.NREQ(NREQ), .AXI_AW(AW), .AXI_DW(DW), .AXI_IDW(IDW), .MAX_OUTS(MO)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs change at posedge+1; outputs are inspected one more time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
        s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_aw(input int r, input logic [31:0] a, input logic [7:0] l);
        s_awaddr[r*AW +: AW] = a;
        s_awlen[r*8 +: 8]    = l;
        s_awsize[r*3 +: 3]   = 3'd3;
        s_awburst[r*2 +: 2]  = 2'd1;
    endtask

    task automatic wait_awv(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (m_axi_awvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s timeout: m_axi_awvalid=%b required 1 within 8 cycles", nm, m_axi_awvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_chk++; if (m_axi_awvalid !== 1'b0) $display("FAIL rst_awvalid act=%b exp=0", m_axi_awvalid); else n_pass++;
        n_chk++; if (m_axi_wvalid !== 1'b0) $display("FAIL rst_wvalid act=%b exp=0", m_axi_wvalid); else n_pass++;
        n_chk++; if (s_awready !== 2'b00) $display("FAIL rst_s_awready act=%b exp=00", s_awready); else n_pass++;
        n_chk++; if (s_wready !== 2'b00) $display("FAIL rst_s_wready act=%b exp=00", s_wready); else n_pass++;
        n_chk++; if (s_bvalid !== 2'b00) $display("FAIL rst_s_bvalid act=%b exp=00", s_bvalid); else n_pass++;
        n_chk++; if (m_axi_bready !== 1'b0) $display("FAIL rst_bready act=%b exp=0", m_axi_bready); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy); else n_pass++;
        n_chk++; if (dut.outs_q !== 3'd0) $display("FAIL rst_outs act=%0d exp=0", dut.outs_q); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_aw(0, 32'h1000_0000, 8'd3);
        s_awvalid = 2'b01;
        m_axi_awready = 1'b1;
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b0) $display("FAIL single_idle_cycle awvalid act=%b exp=0", m_axi_awvalid); else n_pass++;
        tick();
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b1) $display("FAIL single_awvalid act=%b exp=1", m_axi_awvalid); else n_pass++;
        n_chk++; if (m_axi_awid !== 2'd0) $display("FAIL single_awid act=%0d exp=0", m_axi_awid); else n_pass++;
        n_chk++; if (m_axi_awaddr !== 32'h1000_0000) $display("FAIL single_awaddr act=%h exp=10000000", m_axi_awaddr); else n_pass++;
        n_chk++; if (m_axi_awlen !== 8'd3) $display("FAIL single_awlen act=%0d exp=3", m_axi_awlen); else n_pass++;
        n_chk++; if (s_awready !== 2'b01) $display("FAIL single_s_awready act=%b exp=01", s_awready); else n_pass++;
        tick();
        s_awvalid = 2'b00;
        m_axi_wready = 1'b1;
        s_wstrb[7:0] = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            s_wvalid[0] = 1'b1;
            s_wdata[63:0] = 64'(64'hA0 + b);
            s_wlast[0] = (b == 3);
            #1;
            n_chk++;
            if ({m_axi_wvalid, m_axi_wlast, m_axi_wdata} !== {1'b1, (b == 3), 64'(64'hA0 + b)})
                $display("FAIL single_wbeat%0d act v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         b, m_axi_wvalid, m_axi_wlast, m_axi_wdata, (b == 3), 64'(64'hA0 + b));
            else n_pass++;
            tick();
        end
        s_wvalid = '0;
        s_wlast = '0;
        #1;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy_outstanding act=%b exp=1", busy); else n_pass++;
        m_axi_bvalid = 1'b1; m_axi_bid = 2'd0; m_axi_bresp = 2'b00; s_bready = 2'b01;
        #1;
        n_chk++; if (s_bvalid !== 2'b01) $display("FAIL single_s_bvalid act=%b exp=01", s_bvalid); else n_pass++;
        n_chk++; if (m_axi_bready !== 1'b1) $display("FAIL single_bready act=%b exp=1", m_axi_bready); else n_pass++;
        tick();
        m_axi_bvalid = 1'b0;
        s_bready = '0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_end act=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_wr;
        logic [63:0] exp_d;
        do_reset();
        set_aw(0, 32'h2000_0000, 8'd0);
        set_aw(1, 32'h3000_0000, 8'd0);
        s_wdata[63:0]   = 64'h1111;
        s_wdata[127:64] = 64'h2222;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_wlast = 2'b11;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_awv("contention_aw");
            n_chk++; if (m_axi_awid !== 2'(g % 2)) $display("FAIL contention_grant%0d act=%0d exp=%0d", g, m_axi_awid, g % 2); else n_pass++;
            tick();
            exp_wr = (g % 2 == 1) ? 2'b10 : 2'b01;
            exp_d  = (g % 2 == 1) ? 64'h2222 : 64'h1111;
            #1;
            n_chk++; if (s_wready !== exp_wr) $display("FAIL contention_s_wready%0d act=%b exp=%b", g, s_wready, exp_wr); else n_pass++;
            n_chk++; if (m_axi_wdata !== exp_d) $display("FAIL contention_wdata%0d act=%h exp=%h", g, m_axi_wdata, exp_d); else n_pass++;
            tick();
        end
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
        s_bready = 2'b11;
        m_axi_bvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            m_axi_bid = 2'(k % 2);
            tick();
        end
        m_axi_bvalid = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL contention_drain busy act=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] pat;
        int beat;
        pat = 8'b1111_1001;
        beat = 0;
        do_reset();
        set_aw(0, 32'h4000_0000, 8'd3);
        s_awvalid = 2'b01;
        m_axi_awready = 1'b1;
        wait_awv("bp_aw");
        tick();
        s_awvalid = '0;
        for (int c = 0; c < 8 && beat < 4; c++) begin
            m_axi_wready = pat[c];
            s_wvalid[0] = 1'b1;
            s_wdata[63:0] = 64'(64'hB0 + beat);
            s_wlast[0] = (beat == 3);
            #1;
            n_chk++; if (s_wready !== {1'b0, pat[c]}) $display("FAIL bp_s_wready_c%0d act=%b exp=0%b", c, s_wready, pat[c]); else n_pass++;
            n_chk++; if (m_axi_wdata !== 64'(64'hB0 + beat)) $display("FAIL bp_wdata_c%0d act=%h exp=%h", c, m_axi_wdata, 64'(64'hB0 + beat)); else n_pass++;
            if (pat[c]) beat++;
            tick();
        end
        #1;
        n_chk++; if (m_axi_wvalid !== 1'b0) $display("FAIL bp_left_w wvalid act=%b exp=0", m_axi_wvalid); else n_pass++;
        s_wvalid = '0; s_wlast = '0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 2'd0; s_bready = 2'b01;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL bp_busy_end act=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_cap_and_simul();
        int cnt;
        cnt = 0;
        do_reset();
        set_aw(0, 32'h6000_0000, 8'd0);
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_wlast = 2'b01;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_axi_awvalid && m_axi_awready) cnt++;
            tick();
        end
        n_chk++; if (cnt != MO) $display("FAIL cap_aw_count act=%0d exp=%0d", cnt, MO); else n_pass++;
        n_chk++; if (dut.outs_q !== 3'd4) $display("FAIL cap_outs act=%0d exp=4", dut.outs_q); else n_pass++;
        m_axi_bvalid = 1'b1; m_axi_bid = 2'd0; s_bready = 2'b01;
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b0) $display("FAIL cap_hold awvalid act=%b exp=0", m_axi_awvalid); else n_pass++;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b0) $display("FAIL cap_idle_cycle awvalid act=%b exp=0", m_axi_awvalid); else n_pass++;
        n_chk++; if (dut.outs_q !== 3'd3) $display("FAIL cap_after_b outs act=%0d exp=3", dut.outs_q); else n_pass++;
        tick();
        m_axi_bvalid = 1'b1; m_axi_bid = 2'd0; s_bready = 2'b01;
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b1) $display("FAIL cap_resume awvalid act=%b exp=1", m_axi_awvalid); else n_pass++;
        tick();
        n_chk++; if (dut.outs_q !== 3'd3) $display("FAIL simul_aw_b outs act=%0d exp=3", dut.outs_q); else n_pass++;
        s_awvalid = '0;
        m_axi_bid = 2'd1; m_axi_bresp = 2'b10; s_bready = 2'b10;
        #1;
        n_chk++; if (s_bvalid !== 2'b10) $display("FAIL simul_bid1 s_bvalid act=%b exp=10", s_bvalid); else n_pass++;
        n_chk++; if (m_axi_bready !== 1'b1) $display("FAIL simul_bid1 bready act=%b exp=1", m_axi_bready); else n_pass++;
        n_chk++; if (s_bresp !== 4'b1010) $display("FAIL simul_bresp act=%b exp=1010", s_bresp); else n_pass++;
        n_chk++; if ({m_axi_wvalid, s_wready} !== 3'b101) $display("FAIL simul_w_not_stalled act=%b exp=101", {m_axi_wvalid, s_wready}); else n_pass++;
        tick();
        n_chk++; if (dut.outs_q !== 3'd2) $display("FAIL simul_after outs act=%0d exp=2", dut.outs_q); else n_pass++;
        m_axi_bid = 2'd2; m_axi_bresp = 2'b00; s_bready = 2'b00;
        #1;
        n_chk++; if ({m_axi_bready, s_bvalid} !== 3'b100) $display("FAIL sink_bid2 act=%b exp=100", {m_axi_bready, s_bvalid}); else n_pass++;
        tick();
        n_chk++; if (dut.outs_q !== 3'd1) $display("FAIL sink_bid2_counted outs act=%0d exp=1", dut.outs_q); else n_pass++;
        m_axi_bid = 2'd0; s_bready = 2'b01;
        tick();
        m_axi_bid = 2'd2; s_bready = 2'b00;
        tick();
        n_chk++; if (dut.outs_q !== 3'd0) $display("FAIL underflow outs act=%0d exp=0", dut.outs_q); else n_pass++;
        m_axi_bvalid = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL cap_busy_end act=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_w();
        do_reset();
        set_aw(0, 32'h5000_0000, 8'd7);
        s_awvalid = 2'b01;
        m_axi_awready = 1'b1;
        wait_awv("rstw_aw");
        tick();
        s_awvalid = '0;
        m_axi_wready = 1'b1;
        s_wvalid[0] = 1'b1;
        s_wdata[63:0] = 64'hC0;
        tick();
        s_wdata[63:0] = 64'hC1;
        rst = 1'b1;
        tick();
        n_chk++; if ({m_axi_awvalid, m_axi_wvalid} !== 2'b00) $display("FAIL rstw_valids act=%b exp=00", {m_axi_awvalid, m_axi_wvalid}); else n_pass++;
        n_chk++; if ({s_awready, s_wready} !== 4'b0000) $display("FAIL rstw_readies act=%b exp=0000", {s_awready, s_wready}); else n_pass++;
        n_chk++; if (dut.outs_q !== 3'd0) $display("FAIL rstw_outs act=%0d exp=0", dut.outs_q); else n_pass++;
        n_chk++; if (dut.state_q !== ST_IDLE) $display("FAIL rstw_state act=%0d exp=0", dut.state_q); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstw_busy act=%b exp=0", busy); else n_pass++;
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_cap_and_simul();
        test_reset_mid_w();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
